// File: rtl/spi_peripheral_if.sv
// Bundle of SPI pins plus the host-side TX/RX/status handshake for spi_peripheral.
// The peripheral uses the slave modport; the driving controller/host side uses master.
interface spi_peripheral_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_spi_clk;
  logic                  i_spi_cs;
  logic                  i_spi_mosi;
  logic                  o_spi_miso;
  logic                  o_spi_miso_oe;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  i_rx_ready;
  logic                  o_busy;
  logic                  o_overrun;
  logic                  o_underrun;
  logic                  i_clr_status;

  modport slave (
    input  i_spi_clk, i_spi_cs, i_spi_mosi, i_tx_data, i_tx_valid, i_rx_ready, i_clr_status,
    output o_spi_miso, o_spi_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy,
    output o_overrun, o_underrun
  );

  modport master (
    output i_spi_clk, i_spi_cs, i_spi_mosi, i_tx_data, i_tx_valid, i_rx_ready, i_clr_status,
    input  o_spi_miso, o_spi_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy,
    input  o_overrun, o_underrun
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI peripheral with oversampled (synchronized) SCLK/CS/MOSI, one-deep TX buffer and RX register.
// Define SPI_PERIPHERAL_STATUS_EN to enable the sticky overrun/underrun status flags.
module spi_peripheral #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input logic             i_clk,
  input logic             i_rst_n,
  spi_peripheral_if.slave bus
);
  localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      ACTIVE  = 1'b1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic [1:0]            sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                  sclk_prev_q, cs_prev_q;
  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  start_pend_q, start_pend_d;
  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge, cs_fall, cs_rise;
  logic                  load, frame_done, tx_write, busy;
  logic                  overrun_set, underrun_set;

  assign sclk_s      = sclk_sync_q[1];
  assign cs_s        = cs_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign busy        = (state_q == ACTIVE);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    start_pend_d = start_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    load         = 1'b0;
    frame_done   = 1'b0;
    if (bus.i_rx_ready) rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d      = ACTIVE;
          bit_cnt_d    = '0;
          rx_shift_d   = '0;
          // CPHA=1 defers the load to the first shift edge
          start_pend_d = CPHA;
          load         = ~CPHA;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d      = IDLE;
          bit_cnt_d    = '0;
          rx_shift_d   = '0;
          start_pend_d = 1'b0;
        end else begin
          if (shift_edge) begin
            if (start_pend_q) begin
              load         = 1'b1;
              start_pend_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d    = '0;
              frame_done   = 1'b1;
              start_pend_d = 1'b1;
              rx_data_d    = rx_shift_d;
              rx_valid_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) tx_shift_d = tx_ready_q ? '0 : tx_buf_q;
  end

  // A write racing a frame-start load is accepted: the load takes the old buffer contents.
  assign tx_write     = bus.i_tx_valid & (tx_ready_q | load);
  assign tx_buf_d     = tx_write ? bus.i_tx_data : tx_buf_q;
  assign tx_ready_d   = tx_write ? 1'b0 : (load ? 1'b1 : tx_ready_q);
  assign underrun_set = load & tx_ready_q;
  assign overrun_set  = frame_done & rx_valid_q & ~bus.i_rx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q  <= {2{CPOL}};
      cs_sync_q    <= 2'b11;
      mosi_sync_q  <= 2'b00;
      sclk_prev_q  <= CPOL;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_buf_q     <= '0;
      rx_data_q    <= '0;
      tx_ready_q   <= 1'b1;
      rx_valid_q   <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], bus.i_spi_clk};
      cs_sync_q    <= {cs_sync_q[0], bus.i_spi_cs};
      mosi_sync_q  <= {mosi_sync_q[0], bus.i_spi_mosi};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_buf_q     <= tx_buf_d;
      rx_data_q    <= rx_data_d;
      tx_ready_q   <= tx_ready_d;
      rx_valid_q   <= rx_valid_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign bus.o_busy        = busy;
  assign bus.o_spi_miso_oe = busy;
  assign bus.o_spi_miso    = busy & tx_shift_q[DATA_WIDTH-1];
  assign bus.o_tx_ready    = tx_ready_q;
  assign bus.o_rx_data     = rx_data_q;
  assign bus.o_rx_valid    = rx_valid_q;

`ifdef SPI_PERIPHERAL_STATUS_EN
  logic overrun_q, underrun_q;

  // Set wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (overrun_set)             overrun_q  <= 1'b1;
      else if (bus.i_clr_status)   overrun_q  <= 1'b0;
      if (underrun_set)            underrun_q <= 1'b1;
      else if (bus.i_clr_status)   underrun_q <= 1'b0;
    end
  end

  assign bus.o_overrun  = overrun_q;
  assign bus.o_underrun = underrun_q;
`else
  logic unused_status;
  assign unused_status  = ^{bus.i_clr_status, overrun_set, underrun_set};
  assign bus.o_overrun  = 1'b0;
  assign bus.o_underrun = 1'b0;
`endif
endmodule
